// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit (AND/OR/XOR/NAND) that resolves CHUNK result bits
// per cycle, LSB chunk first, behind valid/ready handshakes on both sides.
`timescale 1ns/1ps

module logic_unit_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng
);

    localparam int NBEATS = WIDTH / CHUNK;
    localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [1:0]        op_q, op_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic              last_beat;

    assign last_beat = (cnt_q == CW'(NBEATS - 1));

    // Each chunk owns its slice of the result register; only the chunk selected
    // by the beat counter is rewritten, all others hold.
    genvar gi;
    generate
        for (gi = 0; gi < NBEATS; gi++) begin : g_chunk
            logic [CHUNK-1:0] a_c;
            logic [CHUNK-1:0] b_c;
            logic [CHUNK-1:0] res_c;
            logic             wr_en;

            assign a_c   = a_q[gi*CHUNK +: CHUNK];
            assign b_c   = b_q[gi*CHUNK +: CHUNK];
            assign wr_en = (state_q == S_BUSY) && (cnt_q == CW'(gi));

            always_comb begin
                res_c = '0;
                case (op_q)
                    OP_AND:  res_c = a_c & b_c;
                    OP_OR:   res_c = a_c | b_c;
                    OP_XOR:  res_c = a_c ^ b_c;
                    OP_NAND: res_c = ~(a_c & b_c);
                    default: res_c = '0;
                endcase
            end

            assign out_d[gi*CHUNK +: CHUNK] = wr_en ? res_c : out_q[gi*CHUNK +: CHUNK];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                // Counter parks on the final beat rather than wrapping.
                if (last_beat) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out       = out_q;
    assign zr        = (out_q == '0);
    assign ng        = out_q[WIDTH-1];

endmodule

// File: tb/tb_logic_unit_seq.sv
// Directed bench for logic_unit_seq: three parameterisations driven in sequence,
// expected results queued at acceptance and compared when the result is presented.
`timescale 1ns/1ps

module tb_logic_unit_seq;

    logic clk;
    logic reset;

    logic        iv16, ir16, ov16, or16, zr16, ng16;
    logic [15:0] a16, b16, out16;
    logic [1:0]  op16;

    logic        iv8, ir8, ov8, or8, zr8, ng8;
    logic [7:0]  a8, b8, out8;
    logic [1:0]  op8;

    logic        iv32, ir32, ov32, or32, zr32, ng32;
    logic [31:0] a32, b32, out32;
    logic [1:0]  op32;

    int errors;
    int checks;
    int cyc;
    logic [63:0] sb_q[$];

    logic_unit_seq #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .op(op16), .out_valid(ov16), .out_ready(or16),
        .out(out16), .zr(zr16), .ng(ng16)
    );

    logic_unit_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .op(op8), .out_valid(ov8), .out_ready(or8),
        .out(out8), .zr(zr8), .ng(ng8)
    );

    logic_unit_seq #(.WIDTH(32), .CHUNK(4)) dut32 (
        .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32),
        .a(a32), .b(b32), .op(op32), .out_valid(ov32), .out_ready(or32),
        .out(out32), .zr(zr32), .ng(ng32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [63:0] av, input logic [63:0] bv,
                                          input logic [1:0] o, input int w);
        logic [63:0] mask;
        logic [63:0] r;
        mask = (64'd1 << w) - 64'd1;
        case (o)
            2'b00:   r = av & bv;
            2'b01:   r = av | bv;
            2'b10:   r = av ^ bv;
            default: r = ~(av & bv);
        endcase
        return r & mask;
    endfunction

    function automatic logic [63:0] obs_out(input int s);
        case (s)
            0:       return {48'd0, out16};
            1:       return {56'd0, out8};
            default: return {32'd0, out32};
        endcase
    endfunction

    function automatic logic obs_valid(input int s);
        case (s)
            0:       return ov16;
            1:       return ov8;
            default: return ov32;
        endcase
    endfunction

    function automatic logic obs_rdy(input int s);
        case (s)
            0:       return ir16;
            1:       return ir8;
            default: return ir32;
        endcase
    endfunction

    function automatic logic obs_zr(input int s);
        case (s)
            0:       return zr16;
            1:       return zr8;
            default: return zr32;
        endcase
    endfunction

    function automatic logic obs_ng(input int s);
        case (s)
            0:       return ng16;
            1:       return ng8;
            default: return ng32;
        endcase
    endfunction

    task automatic drive(input int s, input logic v, input logic [63:0] av,
                         input logic [63:0] bv, input logic [1:0] o);
        case (s)
            0: begin iv16 = v; a16 = av[15:0]; b16 = bv[15:0]; op16 = o; end
            1: begin iv8  = v; a8  = av[7:0];  b8  = bv[7:0];  op8  = o; end
            default: begin iv32 = v; a32 = av[31:0]; b32 = bv[31:0]; op32 = o; end
        endcase
    endtask

    task automatic set_ordy(input int s, input logic v);
        case (s)
            0:       or16 = v;
            1:       or8  = v;
            default: or32 = v;
        endcase
    endtask

    task automatic pop_chk(input string tag, input int s, input int w);
        logic [63:0] e;
        logic        e_ng;
        checks++;
        assert (sb_q.size() > 0) else begin
            errors++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb_q.size() > 0) begin
            e    = sb_q.pop_front();
            e_ng = e[w-1];
            $display("txn %s: dut=%0d out=%0h exp=%0h", tag, s, obs_out(s), e);
            chk({tag, "_out"}, obs_out(s), e);
            chk({tag, "_zr"}, {63'd0, obs_zr(s)}, {63'd0, (e == 64'd0)});
            chk({tag, "_ng"}, {63'd0, obs_ng(s)}, {63'd0, e_ng});
        end
    endtask

    // Accept one op, scramble the inputs, wait for the result and check it.
    task automatic run_op(input string tag, input int s, input logic [63:0] av,
                          input logic [63:0] bv, input logic [1:0] o, input int w,
                          input int nb, input bit consume);
        int n;
        chk({tag, "_acc_rdy"}, {63'd0, obs_rdy(s)}, 64'd1);
        drive(s, 1'b1, av, bv, o);
        sb_q.push_back(model(av, bv, o, w));
        tick();
        drive(s, 1'b0, ~av, ~bv, ~o);
        n = 0;
        while (!obs_valid(s) && n < 40) begin
            chk({tag, "_busy_rdy"}, {63'd0, obs_rdy(s)}, 64'd0);
            tick();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(nb));
        chk({tag, "_done_rdy"}, {63'd0, obs_rdy(s)}, 64'd0);
        pop_chk(tag, s, w);
        if (consume) begin
            set_ordy(s, 1'b1);
            tick();
            set_ordy(s, 1'b0);
            chk({tag, "_ret_idle"}, {63'd0, obs_rdy(s)}, 64'd1);
            chk({tag, "_ret_novalid"}, {63'd0, obs_valid(s)}, 64'd0);
        end
    endtask

    initial begin
        int nacc;
        int t0;
        int t1;
        bit acc_now;
        bit done_now;

        errors = 0;
        checks = 0;
        cyc    = 0;
        reset  = 1'b1;
        drive(0, 1'b0, 64'd0, 64'd0, 2'b00);
        drive(1, 1'b0, 64'd0, 64'd0, 2'b00);
        drive(2, 1'b0, 64'd0, 64'd0, 2'b00);
        set_ordy(0, 1'b0);
        set_ordy(1, 1'b0);
        set_ordy(2, 1'b0);

        // Reset state
        tick();
        tick();
        chk("rst_out", obs_out(0), 64'd0);
        chk("rst_valid", {63'd0, ov16}, 64'd0);
        chk("rst_rdy", {63'd0, ir16}, 64'd1);
        chk("rst_zr", {63'd0, zr16}, 64'd1);
        chk("rst_ng", {63'd0, ng16}, 64'd0);
        chk("rst_rdy32", {63'd0, ir32}, 64'd1);
        reset = 1'b0;
        tick();

        // Main function on the 16/4 instance
        run_op("and16", 0, 64'hF0F0, 64'hFF00, 2'b00, 16, 4, 1'b1);
        run_op("xor16", 0, 64'h1234, 64'h1234, 2'b10, 16, 4, 1'b1);
        run_op("nand16", 0, 64'h0000, 64'h0000, 2'b11, 16, 4, 1'b1);

        // Backpressure: DONE holds while inputs toggle
        run_op("or16", 0, 64'h00FF, 64'h0F00, 2'b01, 16, 4, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(0, i[0], 64'($urandom), 64'($urandom), 2'($urandom_range(3)));
            tick();
            chk("bp_out", obs_out(0), 64'h0FFF);
            chk("bp_valid", {63'd0, ov16}, 64'd1);
            chk("bp_rdy", {63'd0, ir16}, 64'd0);
        end
        drive(0, 1'b0, 64'd0, 64'd0, 2'b00);
        set_ordy(0, 1'b1);
        tick();
        set_ordy(0, 1'b0);
        chk("bp_release_rdy", {63'd0, ir16}, 64'd1);
        chk("bp_release_valid", {63'd0, ov16}, 64'd0);
        tick();
        chk("bp_no_reaccept", {63'd0, ir16}, 64'd1);

        // Reset during the second BUSY cycle
        drive(0, 1'b1, 64'hFFFF, 64'hFFFF, 2'b00);
        tick();
        drive(0, 1'b0, 64'd0, 64'd0, 2'b00);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_out", obs_out(0), 64'd0);
        chk("abort_valid", {63'd0, ov16}, 64'd0);
        chk("abort_rdy", {63'd0, ir16}, 64'd1);
        chk("abort_zr", {63'd0, zr16}, 64'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_no_result", {63'd0, ov16}, 64'd0);
        end

        // Back-to-back with in_valid and out_ready held high
        set_ordy(0, 1'b1);
        drive(0, 1'b1, 64'hF0F0, 64'h3C3C, 2'b00);
        nacc = 0;
        t0   = 0;
        t1   = 0;
        for (int i = 0; i < 20; i++) begin
            acc_now  = ir16 && iv16;
            done_now = ov16 && or16;
            if (done_now) pop_chk("b2b", 0, 16);
            if (acc_now) sb_q.push_back(model({48'd0, a16}, {48'd0, b16}, op16, 16));
            tick();
            if (acc_now) begin
                if (nacc == 0) begin
                    t0 = cyc;
                    drive(0, 1'b1, 64'h0F0F, 64'h3030, 2'b01);
                end else begin
                    t1 = cyc;
                    drive(0, 1'b0, 64'd0, 64'd0, 2'b00);
                end
                nacc++;
            end
        end
        set_ordy(0, 1'b0);
        chk("b2b_accepts", 64'(nacc), 64'd2);
        chk("b2b_interval", 64'(t1 - t0), 64'd6);
        chk("b2b_drained", 64'(sb_q.size()), 64'd0);

        // Parameter sweep
        run_op("or8", 1, 64'hA0, 64'h05, 2'b01, 8, 1, 1'b1);
        run_op("xor32", 2, 64'h12345678, 64'hF0F0F0F0, 2'b10, 32, 8, 1'b1);
        run_op("nand32", 2, 64'hFFFF0000, 64'hFF00FF00, 2'b11, 32, 8, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/logic_unit_seq.md
Name: logic_unit_seq

Overview:
- Parametrised, multi-cycle, registered bitwise logic unit. It generalises the 16-bit combinational AND to any WIDTH, four ops (AND/OR/XOR/NAND) and CHUNK-bits-per-cycle processing.
- Valid/ready handshake on input and output sides.
- Sits between the Hack-CPU datapath and area-constrained peripherals that trade latency for fewer gates.
- Exports Hack-style zr/ng flags on the registered result.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits computed per BUSY cycle; NBEATS = WIDTH/CHUNK; CHUNK == WIDTH gives single-beat operation.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  a/b/op are valid.
- in_ready  output  1  unit can accept an operation (high only in IDLE).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NAND.
- out_valid  output  1  result available (high only in DONE).
- out_ready  input  1  consumer accepts result.
- out  output  WIDTH  registered result.
- zr  output  1  1 when out == 0 (combinational from out register).
- ng  output  1  out[WIDTH-1] (combinational from out register).

Behaviour:
- Reset: one clock with reset high forces state=IDLE, beat counter=0, out=0, out_valid=0, in_ready=1, zr=1, ng=0. Latched operands and op are cleared to 0.
- Reset overrides every other input in the same cycle, including an in-flight operation (BUSY or DONE). Partial result is discarded; no out_valid pulse follows.
- Output decode:
  - in_ready = (state == IDLE).
  - out_valid = (state == DONE).
  - Both are decoded from state only; there is no combinational path from in_valid/out_ready to either.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_valid && in_ready at a rising edge latches a, b and op into internal registers, clears the beat counter and moves to BUSY.
  - out keeps its previous value until overwritten beat by beat.
- BUSY:
  - Each cycle computes out[k*CHUNK +: CHUNK] = f(a_l, b_l, op_l) slice for beat k = counter, then increments the counter.
  - When counter == NBEATS-1, the final slice is written and the state moves to DONE.
  - Slices are written LSB chunk first.
- DONE:
  - out, zr and ng are stable.
  - out_ready high at a rising edge moves to IDLE.
  - out_ready low holds DONE indefinitely with out stable.
- Latency:
  - Accept at edge T; out_valid rises after edge T+NBEATS. For WIDTH=16, CHUNK=4 that is 4 cycles.
  - Minimum initiation interval is NBEATS+2 cycles: no bypass from DONE to BUSY.
- Input side:
  - in_valid outside IDLE is ignored; no buffering.
  - a, b and op may change freely after acceptance; only latched copies are used.
- Intermediate visibility: out may show mixed old/new chunks while BUSY. Consumers must qualify out with out_valid. zr and ng are valid only while out_valid=1 or after reset.
- Op encoding is the full 2-bit space; no illegal codes.
- Counter width is clog2(NBEATS), minimum 1 bit. Wrap past NBEATS-1 never occurs.

Test Plan:
- Reset then AND: a=16'hF0F0, b=16'hFF00, op=00 accepted at cycle 0 -> out_valid high after 4 BUSY cycles. out=16'hF000, zr=0, ng=1. in_ready=0 throughout BUSY and DONE.
- XOR equal operands: a=b=16'h1234, op=10 -> out=16'h0000, zr=1, ng=0. Then NAND a=0, b=0, op=11 -> out=16'hFFFF, ng=1.
- Backpressure: after OR of 16'h00FF | 16'h0F00, hold out_ready=0 for 5 cycles while toggling in_valid/a/b -> out stays 16'h0FFF and out_valid stays 1. The op is not re-accepted. Raising out_ready -> IDLE next cycle, in_ready=1.
- Reset mid-operation: assert reset on the 2nd BUSY cycle of an AND -> next cycle out=0, out_valid=0, in_ready=1, zr=1. No result is ever presented for the aborted op.
- Back-to-back with out_ready tied high and in_valid held high with two ops (AND then OR) -> second accept occurs exactly NBEATS+2 cycles after the first. Both results are correct and in order.
- Parameter sweep: WIDTH=8, CHUNK=8, OR of 8'hA0 and 8'h05 -> out=8'hA5 with out_valid 1 cycle after accept, ng=1. Repeat with WIDTH=32, CHUNK=4: latency 8 cycles.
